// File: rtl/bp_inflight_queue.sv
// In-order queue of branch predictions awaiting resolution; emits PHT training
// updates and a mispredict flush when the oldest branch resolves.
module bp_inflight_queue #(
    parameter int HIST_W  = 12,
    parameter int DEPTH   = 8,
    parameter int PC_W    = 32,
    parameter int HASH_PC = 1
) (
    input  logic                     CLK,
    input  logic                     RESET,
    input  logic                     push_valid,
    output logic                     push_ready,
    input  logic                     push_pred,
    input  logic [HIST_W-1:0]        push_hist,
    input  logic [PC_W-1:0]          push_pc,
    input  logic                     res_valid,
    input  logic                     res_taken,
    output logic                     upd_valid,
    output logic [HIST_W-1:0]        upd_index,
    output logic                     upd_taken,
    output logic                     upd_mispredict,
    output logic                     flush,
    output logic                     underflow,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic              r_pred [DEPTH];
    logic [HIST_W-1:0] r_idx  [DEPTH];
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [PTR_W-1:0]  r_wr_ptr;

    logic              w_push;
    logic              w_pop;
    logic              w_mis;
    logic              w_flush;
    logic [HIST_W-1:0] w_push_idx;

    // The PHT index is fixed at prediction time, so it is hashed on push.
    always_comb begin
        w_push_idx = (HASH_PC != 0) ? (push_hist ^ push_pc[HIST_W+1:2]) : push_hist;
        w_push     = push_valid && push_ready;
        w_pop      = res_valid && (count != CNT_W'(0));
        w_mis      = res_taken ^ r_pred[r_rd_ptr];
        w_flush    = w_pop && w_mis;
    end

    // Readiness comes from registered occupancy only; a pop never frees a slot the same cycle.
    assign push_ready = (count != CNT_W'(DEPTH));

    // Entry storage; a push coinciding with a flush is wrong-path and never written.
    always_ff @(posedge CLK) begin
        if (w_push && !w_flush) begin
            r_pred[r_wr_ptr] <= push_pred;
            r_idx[r_wr_ptr]  <= w_push_idx;
        end
    end

    // Pointers, occupancy and registered update/flush/underflow outputs.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_rd_ptr       <= '0;
            r_wr_ptr       <= '0;
            count          <= '0;
            upd_valid      <= 1'b0;
            upd_index      <= '0;
            upd_taken      <= 1'b0;
            upd_mispredict <= 1'b0;
            flush          <= 1'b0;
            underflow      <= 1'b0;
        end else begin
            upd_valid      <= w_pop;
            upd_mispredict <= w_flush;
            flush          <= w_flush;
            underflow      <= res_valid && (count == CNT_W'(0));
            if (w_pop) begin
                upd_index <= r_idx[r_rd_ptr];
                upd_taken <= res_taken;
            end else begin
                upd_index <= upd_index;
                upd_taken <= upd_taken;
            end

            if (w_flush) begin
                // Head retires; every younger entry is discarded by collapsing wr onto the new head.
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
                r_wr_ptr <= r_rd_ptr + PTR_W'(1);
                count    <= '0;
            end else begin
                if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + PTR_W'(1);
                end else begin
                    r_wr_ptr <= r_wr_ptr;
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + PTR_W'(1);
                end else begin
                    r_rd_ptr <= r_rd_ptr;
                end
                count <= count + CNT_W'(w_push) - CNT_W'(w_pop);
            end
        end
    end

endmodule

// File: tb/tb_bp_inflight_queue.sv
// Scoreboard bench for bp_inflight_queue: stimulus queues expected updates,
// a negedge monitor checks each upd_valid pulse against them.
module tb_bp_inflight_queue;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        push_valid, push_ready, push_pred;
    logic [11:0] push_hist;
    logic [31:0] push_pc;
    logic        res_valid, res_taken;
    logic        upd_valid, upd_taken, upd_mispredict, flush, underflow;
    logic [11:0] upd_index;
    logic [3:0]  count;

    typedef struct packed { logic [11:0] idx; logic taken; logic mis; } exp_t;
    typedef struct packed { logic pred; logic [11:0] idx; } ent_t;

    exp_t sb [$];
    ent_t mq [$];
    int n_tests = 0;
    int n_fail  = 0;

    bp_inflight_queue #(.HIST_W(12), .DEPTH(8), .PC_W(32), .HASH_PC(1)) dut (
        .CLK(CLK), .RESET(RESET),
        .push_valid(push_valid), .push_ready(push_ready), .push_pred(push_pred),
        .push_hist(push_hist), .push_pc(push_pc),
        .res_valid(res_valid), .res_taken(res_taken),
        .upd_valid(upd_valid), .upd_index(upd_index), .upd_taken(upd_taken),
        .upd_mispredict(upd_mispredict), .flush(flush), .underflow(underflow),
        .count(count)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Monitor: every update pulse must match the oldest queued expectation.
    always @(negedge CLK) begin
        exp_t x;
        if (upd_valid === 1'b1) begin
            n_tests++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL upd_unexpected: got idx %0h taken %0b mis %0b, none expected", upd_index, upd_taken, upd_mispredict);
            end else begin
                x = sb.pop_front();
                if (upd_index !== x.idx || upd_taken !== x.taken || upd_mispredict !== x.mis || flush !== x.mis) begin
                    n_fail++;
                    $display("FAIL upd: got idx %0h taken %0b mis %0b flush %0b, expected idx %0h taken %0b mis %0b flush %0b",
                             upd_index, upd_taken, upd_mispredict, flush, x.idx, x.taken, x.mis, x.mis);
                end
            end
        end else if (flush === 1'b1) begin
            n_tests++;
            n_fail++;
            $display("FAIL flush_alone: got flush 1 expected 0 without upd_valid");
        end
    end

    // One clock of stimulus; the reference queue decides what the DUT should do.
    task automatic cyc(input logic pv, input logic pp, input logic [11:0] ph, input logic [31:0] pc,
                       input logic rv, input logic rt);
        ent_t e;
        exp_t x;
        logic push_ok, pop_ok, exp_uf;
        push_ok = pv && (mq.size() < 8);
        pop_ok  = rv && (mq.size() != 0);
        exp_uf  = rv && (mq.size() == 0);
        e.pred  = pp;
        e.idx   = ph ^ pc[13:2];
        if (pop_ok) begin
            x.idx   = mq[0].idx;
            x.taken = rt;
            x.mis   = rt ^ mq[0].pred;
            sb.push_back(x);
            if (x.mis) begin
                mq.delete();
            end else begin
                void'(mq.pop_front());
                if (push_ok) mq.push_back(e);
            end
        end else if (push_ok) begin
            mq.push_back(e);
        end
        push_valid = pv; push_pred = pp; push_hist = ph; push_pc = pc;
        res_valid = rv; res_taken = rt;
        @(posedge CLK); #1;
        push_valid = 1'b0; res_valid = 1'b0;
        chk("count", 32'(count), 32'(mq.size()));
        chk("push_ready", 32'(push_ready), 32'(mq.size() < 8));
        chk("underflow", 32'(underflow), 32'(exp_uf));
    endtask

    initial begin
        RESET = 1'b1; push_valid = 1'b0; push_pred = 1'b0; push_hist = 12'h000;
        push_pc = 32'h0; res_valid = 1'b0; res_taken = 1'b0;
        repeat (2) @(posedge CLK);
        #1 RESET = 1'b0;
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_ready", 32'(push_ready), 32'd1);
        chk("rst_upd_valid", 32'(upd_valid), 32'd0);
        chk("rst_flush", 32'(flush), 32'd0);
        chk("rst_underflow", 32'(underflow), 32'd0);

        // 1: three correct predictions; expected indices 0x10A, 0x10A, 0x10E
        cyc(1'b1, 1'b1, 12'h00A, 32'h400, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 12'h00B, 32'h404, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 12'h00C, 32'h408, 1'b0, 1'b0);
        chk("t1_idx0", 32'(mq[0].idx), 32'h10A);
        chk("t1_idx2", 32'(mq[2].idx), 32'h10E);
        cyc(1'b0, 1'b0, 12'h000, 32'h0, 1'b1, 1'b1);
        cyc(1'b0, 1'b0, 12'h000, 32'h0, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 12'h000, 32'h0, 1'b1, 1'b1);
        cyc(1'b0, 1'b0, 12'h000, 32'h0, 1'b0, 1'b0);

        // 2: fill to 8, push while full, pop+push while full
        for (int i = 0; i < 8; i++)
            cyc(1'b1, 1'b1, 12'(i * 3), 32'h1000 + 32'(i * 4), 1'b0, 1'b0);
        chk("t2_full_count", 32'(count), 32'd8);
        cyc(1'b1, 1'b0, 12'h7FF, 32'h2000, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 12'h7FE, 32'h2004, 1'b1, 1'b1);
        chk("t2_after_pop", 32'(count), 32'd7);
        for (int i = 0; i < 7; i++)
            cyc(1'b0, 1'b0, 12'h000, 32'h0, 1'b1, 1'b1);
        cyc(1'b0, 1'b0, 12'h000, 32'h0, 1'b0, 1'b0);

        // 3: mispredict on head flushes younger entries and the same-cycle push
        for (int i = 0; i < 4; i++)
            cyc(1'b1, 1'b1, 12'h100 + 12'(i), 32'h3000 + 32'(i * 4), 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 12'h555, 32'h4000, 1'b1, 1'b0);
        chk("t3_flush", 32'(flush), 32'd1);
        chk("t3_count", 32'(count), 32'd0);
        cyc(1'b0, 1'b0, 12'h000, 32'h0, 1'b0, 1'b0);

        // 4: resolve on empty, and push+resolve while empty
        cyc(1'b0, 1'b0, 12'h000, 32'h0, 1'b1, 1'b1);
        chk("t4_no_upd", 32'(upd_valid), 32'd0);
        cyc(1'b1, 1'b0, 12'h0F0, 32'h5000, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 12'h000, 32'h0, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 12'h000, 32'h0, 1'b0, 1'b0);

        // 5: streaming push/pop, pointers wrap several times
        cyc(1'b1, 1'b1, 12'h200, 32'h6000, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            logic p_new, p_old;
            p_new = ((i + 1) % 3) == 0;
            p_old = (i % 3) == 0;
            cyc(1'b1, p_new, 12'h201 + 12'(i), 32'h6004 + 32'(i * 4), 1'b1, p_old);
        end
        cyc(1'b0, 1'b0, 12'h000, 32'h0, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 12'h000, 32'h0, 1'b0, 1'b0);

        // 6: reset with 5 entries and a pending resolve
        for (int i = 0; i < 5; i++)
            cyc(1'b1, 1'b0, 12'h300 + 12'(i), 32'h7000 + 32'(i * 4), 1'b0, 1'b0);
        RESET = 1'b1; res_valid = 1'b1; res_taken = 1'b1;
        @(posedge CLK); #1;
        RESET = 1'b0; res_valid = 1'b0;
        mq.delete();
        chk("t6_count", 32'(count), 32'd0);
        chk("t6_upd_valid", 32'(upd_valid), 32'd0);
        chk("t6_flush", 32'(flush), 32'd0);
        chk("t6_mis", 32'(upd_mispredict), 32'd0);
        chk("t6_index", 32'(upd_index), 32'd0);
        chk("t6_taken", 32'(upd_taken), 32'd0);
        chk("t6_ready", 32'(push_ready), 32'd1);
        cyc(1'b0, 1'b0, 12'h000, 32'h0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 12'h000, 32'h0, 1'b0, 1'b0);

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
